// File: rtl/ram_rf_2p.sv
// Two-port register file: byte-enable writes, write-first bypass, range checking, self-timed clear.
// Optional per-entry even parity with ParErr output when RAM_RF_PARITY_EN is defined.
module ram_rf_2p #(
    parameter int Width  = 16,
    parameter int Depth  = 8,
    parameter int ADD_WD = 3
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                WrEn,
    input  logic [ADD_WD-1:0]   WrAddr,
    input  logic [Width-1:0]    WrData,
    input  logic [Width/8-1:0]  WrBE,
    input  logic                RdEn,
    input  logic [ADD_WD-1:0]   RdAddr,
    input  logic                Clr,
    output logic [Width-1:0]    RdData,
    output logic                RdValid,
    output logic                Busy,
    output logic                AddrErr
`ifdef RAM_RF_PARITY_EN
    ,
    output logic                ParErr
`endif
);

    localparam int                NBYTES  = Width / 8;
    localparam int                ENTRIES = 1 << ADD_WD;
    localparam logic [ADD_WD:0]   DEPTH_W = (ADD_WD + 1)'(Depth);
    localparam logic [ADD_WD-1:0] LAST    = ADD_WD'(Depth - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state_p0;
    logic [ADD_WD-1:0]   clr_cnt_p0;
    logic [Width-1:0]    mem [ENTRIES];

    logic                idle;
    logic                wr_in, rd_in;
    logic                wr_ok, rd_ok;
    logic                addr_err;
    logic                bypass;
    logic [Width-1:0]    wr_word;
    logic [Width-1:0]    rd_word;

    logic [Width-1:0]    rd_data_p1;
    logic                vld_p1;
    logic                addr_err_p1;

    function automatic logic [Width-1:0] merge_bytes(input logic [Width-1:0]  old_w,
                                                     input logic [Width-1:0]  new_w,
                                                     input logic [NBYTES-1:0] be);
        logic [Width-1:0] m;
        m = old_w;
        for (int b = 0; b < NBYTES; b++) begin
            if (be[b]) m[8*b +: 8] = new_w[8*b +: 8];
        end
        return m;
    endfunction

    always_comb begin
        idle     = (state_p0 == IDLE);
        wr_in    = ({1'b0, WrAddr} < DEPTH_W);
        rd_in    = ({1'b0, RdAddr} < DEPTH_W);
        wr_ok    = idle && WrEn && wr_in;
        rd_ok    = idle && RdEn && rd_in;
        // one shared pulse even when both ports are out of range
        addr_err = idle && ((WrEn && !wr_in) || (RdEn && !rd_in));
        bypass   = wr_ok && rd_ok && (WrAddr == RdAddr);
        wr_word  = merge_bytes(mem[WrAddr], WrData, WrBE);
        rd_word  = bypass ? wr_word : mem[RdAddr];
    end

    // stage p0: clear FSM
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_p0   <= IDLE;
            clr_cnt_p0 <= '0;
        end else begin
            case (state_p0)
                IDLE: begin
                    if (Clr) begin
                        state_p0   <= CLEAR;
                        clr_cnt_p0 <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_cnt_p0 == LAST) begin
                        state_p0   <= IDLE;
                        clr_cnt_p0 <= '0;
                    end else begin
                        clr_cnt_p0 <= clr_cnt_p0 + 1'b1;
                    end
                end
                default: begin
                    state_p0   <= IDLE;
                    clr_cnt_p0 <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
        end else if (state_p0 == CLEAR) begin
            mem[clr_cnt_p0] <= '0;
        end else if (wr_ok && (|WrBE)) begin
            mem[WrAddr] <= wr_word;
        end
    end

    // stage p1: registered read port and error strobes
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_data_p1  <= '0;
            vld_p1      <= 1'b0;
            addr_err_p1 <= 1'b0;
        end else begin
            if (rd_ok) rd_data_p1 <= rd_word;
            vld_p1      <= rd_ok;
            addr_err_p1 <= addr_err;
        end
    end

    assign RdData  = rd_data_p1;
    assign RdValid = vld_p1;
    assign AddrErr = addr_err_p1;
    assign Busy    = (state_p0 == CLEAR);

`ifdef RAM_RF_PARITY_EN
    function automatic logic even_par(input logic [Width-1:0] w);
        return ^w;
    endfunction

    logic par_mem [ENTRIES];
    logic rd_par_err;
    logic par_err_p1;

    // a bypassed read returns fresh write data, so it is never flagged
    assign rd_par_err = !bypass && (even_par(mem[RdAddr]) != par_mem[RdAddr]);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < ENTRIES; i++) par_mem[i] <= 1'b0;
            par_err_p1 <= 1'b0;
        end else begin
            if (state_p0 == CLEAR) begin
                par_mem[clr_cnt_p0] <= 1'b0;
            end else if (wr_ok && (|WrBE)) begin
                par_mem[WrAddr] <= even_par(wr_word);
            end
            par_err_p1 <= rd_ok && rd_par_err;
        end
    end

    assign ParErr = par_err_p1;
`endif

endmodule

// File: doc/ram_rf_2p.md
# ram_rf_2p

Parametrised two-port register file and the successor to the 16-bit single-address RAM. It provides independent write and read addresses in the same cycle, byte-enable writes, write-first bypass on address collision, a read-valid strobe, address-range checking and a self-timed clear engine. It serves as the general-purpose storage block for datapath and config-register use, in any width/depth combination.

## Interface
- Width, 16, data word width; must be a multiple of 8.
- Depth, 8, number of entries; 2 ≤ Depth ≤ 2^ADD_WD.
- ADD_WD, 3, address width.
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- WrEn  input  1  write request.
- WrAddr  input  ADD_WD  write address.
- WrData  input  Width  write data.
- WrBE  input  Width/8  byte enables; bit i selects WrData[8i+7:8i].
- RdEn  input  1  read request.
- RdAddr  input  ADD_WD  read address.
- Clr  input  1  start a clear of all entries to zero.
- RdData  output  Width  registered read data; holds its value between reads.
- RdValid  output  1  one-cycle pulse when RdData is updated.
- Busy  output  1  high while the clear engine runs.
- AddrErr  output  1  one-cycle pulse on a dropped out-of-range request.
- ParErr  output  1  parity error on read; present only when RAM_RF_PARITY_EN is defined.

## Operation
- The FSM has two states, IDLE and CLEAR, with a clear counter of ADD_WD bits.
- **Reset (asynchronous, effective mid-operation):**
  - All entries go to 0 and the FSM returns to IDLE.
  - The counter, RdData, RdValid, Busy, AddrErr and ParErr go to 0.
- **Write (IDLE, WrEn=1, WrAddr<Depth):** only the bytes whose WrBE bit is set are updated at the edge. WrBE=0 performs no write and raises no error.
- **Read (IDLE, RdEn=1, RdAddr<Depth):** RdData is loaded with the entry at the edge, and RdValid is high for the following cycle.
- **Collision (read and write to the same address in the same cycle):** write-first. RdData takes WrData in the enabled bytes and the old contents in the other bytes.
- **Out of range (address ≥ Depth):**
  - The offending request is dropped and AddrErr pulses high for one cycle.
  - The other port's valid request still executes.
  - If both ports are out of range, a single pulse is produced.
- **Clear:**
  - Clr sampled high in IDLE moves the FSM to CLEAR with the counter at 0.
  - Each CLEAR cycle zeroes entry[counter] and increments the counter.
  - After entry Depth-1 is cleared, the FSM returns to IDLE.
  - Clr during CLEAR is ignored.
- **Requests during CLEAR:** WrEn and RdEn are ignored. RdValid and AddrErr stay 0, and RdData holds.
- **Clr together with a request in IDLE:** the request executes that cycle and the clear starts next cycle, so the written data is erased.

## Timing
- Read latency is 1 cycle: request at edge k gives RdData/RdValid valid from edge k to edge k+1.
- Back-to-back reads give a RdValid pulse on every cycle.
- Write data is visible to a read at the next edge; the same edge is covered by the bypass.
- Clear timing, with Clr sampled at edge k:
  - Busy is high from edge k to edge k+Depth, i.e. exactly Depth cycles.
  - Edges k+1..k+Depth clear entries 0..Depth-1.
  - The first accepted request is at edge k+Depth+1.
- Busy is decoded from the state register and is glitch-free.
- AddrErr and ParErr are registered, so each pulse appears one cycle after the request.

## Configuration
- **RAM_RF_PARITY_EN defined:**
  - Each entry stores one extra even-parity bit, computed over the merged word on every write; cleared entries store parity 0.
  - On a read, ParErr is high in the same cycle as RdValid if the recomputed parity mismatches the stored bit; otherwise it is 0.
  - A bypassed read never flags an error.
- **RAM_RF_PARITY_EN undefined:** there is no parity storage and no ParErr port; all other behaviour is identical.

## Test plan
- **Reset, write, read:** release RST, write 0xA5C3 to address 5 with WrBE=2'b11, then read address 5. RdData=0xA5C3 with RdValid high for one cycle, one cycle after the read request.
- **Byte enables and bypass:** entry 2 holds 0x1234; write 0xABCD with WrBE=2'b01 while reading address 2 in the same cycle. RdData=0x12CD, and a later read of entry 2 also returns 0x12CD.
- **Clear:** fill all 8 entries with nonzero data, pulse Clr, and issue a write during Busy. Busy is high for exactly 8 cycles, the write is ignored, and every read afterwards returns 0.
- **Out of range:** with Depth=6, write address 7 together with a valid read of address 1. AddrErr pulses once, entry contents are unchanged, and the read completes normally.
- **Reset mid-clear:** assert RST at the 3rd Busy cycle. Busy drops immediately, all entries read 0 after release, and the FSM is in IDLE.
- **Parity (with RAM_RF_PARITY_EN):** write 0x0001 to address 3, force the stored bit 4 to 1, then read address 3. ParErr=1 with RdValid; an unforced read of another entry gives ParErr=0.
